// File: rtl/tank_arbiter.sv
// Round-robin arbiter for the shared wort line/tank, with overfill hysteresis and valve-settle gap.
// Latency: grant registered 1 cycle after request; release 1 cycle after condition; 1 GUARD cycle follows.
// Backpressure: requests are level-held by kettles; unserved requests wait through GUARD/FULL.
// Optional watchdog: define TANK_ARB_WATCHDOG_EN to add the hold counter and timeout release.
module tank_arbiter #(
  parameter int N_KETTLE  = 4,
  parameter int TANK_MAX  = 200,
  parameter int TANK_HYST = 20,
  parameter int TIMEOUT   = 255
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_KETTLE-1:0]         req,
  input  logic [N_KETTLE-1:0]         done,
  input  logic [7:0]                  tank_level,
  output logic [N_KETTLE-1:0]         grant,
  output logic [$clog2(N_KETTLE)-1:0] grant_id,
  output logic                        busy,
  output logic                        tank_full,
  output logic                        timeout_err,
  output logic [7:0]                  xfer_count
);

  localparam int IW = $clog2(N_KETTLE);
  localparam logic [7:0] FULL_LVL   = 8'(TANK_MAX);
  localparam logic [7:0] RESUME_LVL = 8'(TANK_MAX - TANK_HYST);

  // Reject parameter sets the arbiter cannot honour.
  if (N_KETTLE < 2 || N_KETTLE > 8 || TIMEOUT < 2 || TANK_HYST >= TANK_MAX || TANK_MAX > 255) begin : g_param_check
    $error("tank_arbiter: unsupported parameter combination");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GUARD  = 2'd2,
    FULL   = 2'd3
  } state_t;

  state_t              state_q, state_n;
  logic [N_KETTLE-1:0] grant_q, grant_n;
  logic [IW-1:0]       gid_q, gid_n;
  logic [IW-1:0]       ptr_q, ptr_n;
  logic [7:0]          cnt_q, cnt_n;
  logic [IW-1:0]       win;
  logic                found;
  logic                rel;
  int                  idx;

`ifdef TANK_ARB_WATCHDOG_EN
  localparam int HW = $clog2(TIMEOUT);
  logic [HW-1:0] hold_q, hold_n;
  logic          terr_q, terr_n;
  assign timeout_err = terr_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign grant      = grant_q;
  assign grant_id   = gid_q;
  assign xfer_count = cnt_q;
  assign busy       = (state_q == ACTIVE) || (state_q == GUARD);
  assign tank_full  = (state_q == FULL);

  // Next-state, round-robin winner search and release decisions.
  always_comb begin
    state_n = state_q;
    grant_n = grant_q;
    gid_n   = gid_q;
    ptr_n   = ptr_q;
    cnt_n   = cnt_q;
    found   = 1'b0;
    win     = '0;
    rel     = 1'b0;
    idx     = 0;
`ifdef TANK_ARB_WATCHDOG_EN
    hold_n  = hold_q;
    terr_n  = 1'b0;
`endif

    // First requester after the last winner, wrapping around.
    for (int i = 1; i <= N_KETTLE; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= N_KETTLE) idx = idx - N_KETTLE;
      if (!found && req[idx[IW-1:0]]) begin
        found = 1'b1;
        win   = idx[IW-1:0];
      end
    end

    case (state_q)
      IDLE: begin
        if (tank_level >= FULL_LVL) begin
          state_n = FULL;
        end else if (found) begin
          state_n      = ACTIVE;
          grant_n      = '0;
          grant_n[win] = 1'b1;
          gid_n        = win;
          ptr_n        = win;
`ifdef TANK_ARB_WATCHDOG_EN
          hold_n       = '0;
`endif
        end
      end
      ACTIVE: begin
        // Completion outranks overfill, which outranks the watchdog.
        if (done[gid_q] || !req[gid_q]) begin
          rel   = 1'b1;
          cnt_n = cnt_q + 8'd1;
        end else if (tank_level >= FULL_LVL) begin
          rel = 1'b1;
`ifdef TANK_ARB_WATCHDOG_EN
        end else if (hold_q == HW'(TIMEOUT - 1)) begin
          rel    = 1'b1;
          terr_n = 1'b1;
`endif
        end
        if (rel) begin
          state_n = GUARD;
          grant_n = '0;
          gid_n   = '0;
        end
`ifdef TANK_ARB_WATCHDOG_EN
        else if (hold_q != {HW{1'b1}}) begin
          hold_n = hold_q + HW'(1);
        end
`endif
      end
      GUARD: begin
        // Hysteresis also blocks re-grants when a completion left the tank nearly full.
        state_n = (tank_level >= RESUME_LVL) ? FULL : IDLE;
      end
      FULL: begin
        if (tank_level < RESUME_LVL) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      gid_q   <= '0;
      ptr_q   <= IW'(N_KETTLE - 1);
      cnt_q   <= '0;
`ifdef TANK_ARB_WATCHDOG_EN
      hold_q  <= '0;
      terr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_n;
      grant_q <= grant_n;
      gid_q   <= gid_n;
      ptr_q   <= ptr_n;
      cnt_q   <= cnt_n;
`ifdef TANK_ARB_WATCHDOG_EN
      hold_q  <= hold_n;
      terr_q  <= terr_n;
`endif
    end
  end

endmodule

// File: tb/tb_tank_arbiter.sv
// Bench for tank_arbiter: directed kettle scenarios, behavioural model compared every cycle.
// Latency: model advanced on each rising edge, DUT compared on the falling edge.
// Backpressure: not applicable; requests are held by the stimulus until served.
module tb_tank_arbiter;

  localparam int N    = 4;
  localparam int MAX  = 200;
  localparam int HYST = 20;
  localparam int TOUT = 10;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic [3:0] done;
  logic [7:0] tank_level;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       busy;
  logic       tank_full;
  logic       timeout_err;
  logic [7:0] xfer_count;

  int n_pass  = 0;
  int n_total = 0;

  tank_arbiter #(.N_KETTLE(N), .TANK_MAX(MAX), .TANK_HYST(HYST), .TIMEOUT(TOUT)) dut (
    .clk(clk), .reset(reset), .req(req), .done(done), .tank_level(tank_level),
    .grant(grant), .grant_id(grant_id), .busy(busy), .tank_full(tank_full),
    .timeout_err(timeout_err), .xfer_count(xfer_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void chk(string name, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endfunction

  // Behavioural model: who owns the line, whether we sit in the settle gap or overfill hold.
  int owner = -1;
  int last  = N - 1;
  int held  = 0;
  int count = 0;
  bit settle = 0;
  bit full   = 0;
  bit terr   = 0;
  bit m_ok   = 0;

  // Advance the model with the inputs present at this edge.
  always @(posedge clk) begin
    int  lvl;
    bit  release_now;
    bit  picked;
    int  k;
    lvl = int'(tank_level);
    release_now = 0;
    picked = 0;
    if (!reset) begin
      owner = -1; last = N - 1; held = 0; count = 0;
      settle = 0; full = 0; terr = 0;
    end else begin
      terr = 0;
      if (settle) begin
        settle = 0;
        full = (lvl >= MAX - HYST);
      end else if (full) begin
        full = (lvl >= MAX - HYST);
      end else if (owner >= 0) begin
        if (done[owner] || !req[owner]) begin
          release_now = 1;
          count = (count + 1) % 256;
        end else if (lvl >= MAX) begin
          release_now = 1;
        end
`ifdef TANK_ARB_WATCHDOG_EN
        else if (held == TOUT) begin
          release_now = 1;
          terr = 1;
        end
`endif
        if (release_now) begin
          owner = -1;
          settle = 1;
        end else begin
          held++;
        end
      end else if (lvl >= MAX) begin
        full = 1;
      end else begin
        for (int i = 1; i <= N; i++) begin
          k = (last + i) % N;
          if (!picked && req[k]) begin
            picked = 1;
            owner = k;
            last = k;
            held = 1;
          end
        end
      end
    end
    m_ok = 1;
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (m_ok) begin
      chk("grant",       int'(grant),       (owner >= 0) ? (1 << owner) : 0);
      chk("grant_id",    int'(grant_id),    (owner >= 0) ? owner : 0);
      chk("busy",        int'(busy),        (owner >= 0 || settle) ? 1 : 0);
      chk("tank_full",   int'(tank_full),   full ? 1 : 0);
      chk("timeout_err", int'(timeout_err), terr ? 1 : 0);
      chk("xfer_count",  int'(xfer_count),  count);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int exp_order [5] = '{0, 1, 2, 3, 0};
  int n_held;

  initial begin
    reset = 1'b0; req = '0; done = '0; tank_level = 8'd0;
    tick(2);
    chk("rst_grant", int'(grant), 0);
    chk("rst_xfer",  int'(xfer_count), 0);
    chk("rst_busy",  int'(busy), 0);
    reset = 1'b1;
    tick(1);

    // Single request, completion, settle gap.
    req = 4'b0100;
    tick(1);
    chk("single_grant", int'(grant), 4);
    chk("single_id",    int'(grant_id), 2);
    tick(5);
    done = 4'b0100; req = 4'b0000;
    tick(1);
    done = 4'b0000;
    chk("single_rel_grant", int'(grant), 0);
    chk("single_rel_xfer",  int'(xfer_count), 1);
    chk("single_guard_busy", int'(busy), 1);
    tick(1);
    chk("single_idle_busy", int'(busy), 0);

    // Fresh pointer, then round-robin across all kettles.
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    req = 4'b1111;
    tick(1);
    for (int g = 0; g < 5; g++) begin
      chk("rr_grant", int'(grant), 1 << exp_order[g]);
      tick(2);
      done = grant;
      if (g == 4) req = 4'b0000;
      tick(1);
      done = 4'b0000;
      chk("rr_guard_grant", int'(grant), 0);
      chk("rr_guard_busy",  int'(busy), 1);
      tick(1);
      chk("rr_idle_busy", int'(busy), 0);
      tick(1);
    end
    chk("rr_xfer", int'(xfer_count), 5);

    // Overfill during a transfer, then hysteresis release.
    req = 4'b0010;
    tick(1);
    chk("ovf_grant", int'(grant), 2);
    tank_level = 8'd150; tick(1);
    tank_level = 8'd190; tick(1);
    chk("ovf_still_granted", int'(grant), 2);
    tank_level = 8'd200; tick(1);
    chk("ovf_drop", int'(grant), 0);
    chk("ovf_no_count", int'(xfer_count), 5);
    tick(1);
    chk("ovf_full", int'(tank_full), 1);
    tank_level = 8'd180; tick(1);
    chk("ovf_full_at_180", int'(tank_full), 1);
    tank_level = 8'd179; tick(1);
    chk("ovf_exit_full", int'(tank_full), 0);
    tick(1);
    chk("ovf_regrant", int'(grant), 2);
    done = 4'b0010; req = 4'b0000;
    tick(1);
    done = 4'b0000;
    tick(2);

    // Kettle 3 holds the line without ever finishing.
    req = 4'b1000;
    tick(1);
    chk("wd_grant", int'(grant), 8);
    n_held = 1;
    while (grant == 4'b1000 && n_held < 20) begin
      tick(1);
      if (grant == 4'b1000) n_held++;
    end
`ifdef TANK_ARB_WATCHDOG_EN
    chk("wd_hold_cycles", n_held, TOUT);
    chk("wd_pulse", int'(timeout_err), 1);
    req = 4'b1001;
    tick(1);
    chk("wd_pulse_gone", int'(timeout_err), 0);
    tick(1);
    chk("wd_next_winner", int'(grant), 1);
    done = 4'b0001; req = 4'b0000;
    tick(1);
`else
    chk("nowd_hold_cycles", n_held, 20);
    chk("nowd_no_err", int'(timeout_err), 0);
    done = 4'b1000; req = 4'b0000;
    tick(1);
`endif
    done = 4'b0000;
    chk("wd_xfer", int'(xfer_count), 7);
    tick(2);

    // Completion on the very cycle the watchdog would fire.
    req = 4'b0100;
    tick(1);
    chk("sim_grant", int'(grant), 4);
    tick(TOUT - 1);
    done = 4'b0100; req = 4'b0000;
    tick(1);
    done = 4'b0000;
    chk("sim_drop", int'(grant), 0);
    chk("sim_no_err", int'(timeout_err), 0);
    chk("sim_xfer", int'(xfer_count), 8);
    tick(2);

    // Reset in the middle of a transfer.
    req = 4'b0100;
    tick(1);
    chk("rstmid_grant", int'(grant), 4);
    reset = 1'b0;
    tick(1);
    chk("rstmid_grant0", int'(grant), 0);
    chk("rstmid_xfer0",  int'(xfer_count), 0);
    reset = 1'b1;
    req = 4'b1111;
    tick(1);
    chk("rstmid_k0_wins", int'(grant), 1);
    req = 4'b0000;
    tick(3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL sim_time_limit: got timeout, expected completion");
    $fatal(1, "simulation time limit");
  end

endmodule
